instr_fetch_buffer: RTL and testbench
=====================================

INSTR_FETCH_BUFFER -- requirements
Module: instr_fetch_buffer

Interface
REQ-001 Parameter DATA_WIDTH, default 32, instruction word width in bits.
REQ-002 Parameter DEPTH, default 4, number of buffered instructions; SHALL be a power of two, >= 2.
REQ-003 clk  input  1  clock; all state updates on its rising edge.
REQ-004 reset  input  1  synchronous, active-high reset.
REQ-005 waitrequest  input  1  memory stall; high means fetch_data is not valid this cycle.
REQ-006 fetch_valid  input  1  memory returns a fetched word this cycle (qualified by !waitrequest).
REQ-007 fetch_data  input  DATA_WIDTH  fetched instruction word from memory readdata.
REQ-008 consume  input  1  decoder takes the head instruction this cycle.
REQ-009 flush  input  1  discard all buffered instructions (branch/jump redirect).
REQ-010 fetch_ready  output  1  buffer can accept a word this cycle.
REQ-011 instr_valid  output  1  head entry holds a valid instruction.
REQ-012 instr_data  output  DATA_WIDTH  head instruction, held stable until consumed.
REQ-013 count  output  $clog2(DEPTH+1)  number of valid entries, 0..DEPTH.

Function
REQ-014 Push SHALL occur when fetch_valid && !waitrequest && fetch_ready && !flush; the word is written at the tail pointer.
REQ-015 Pop SHALL occur when consume && instr_valid && !flush; the head pointer advances.
REQ-016 fetch_ready SHALL be (count < DEPTH) || (consume && instr_valid), combinational.
REQ-017 instr_valid SHALL equal (count != 0); instr_data SHALL be the head storage entry when valid, 0 when empty.
REQ-018 Fetch-to-output latency SHALL be 1 cycle: a word pushed into an empty buffer appears on instr_data the next cycle.
REQ-019 No combinational path from fetch_data to instr_data.
REQ-020 count update: push only +1; pop only -1; push and pop together unchanged.
REQ-021 Simultaneous push and pop when full SHALL be accepted: head advances, new word written to the freed slot, count stays DEPTH.
REQ-022 Pop when empty (consume with instr_valid low) SHALL be ignored; count stays 0.
REQ-023 Push attempt when full without pop SHALL be dropped; storage and count unchanged; fetch_ready low signals this.
REQ-024 Head and tail pointers SHALL be $clog2(DEPTH) bits and wrap modulo DEPTH.
REQ-025 flush SHALL take priority over push and pop: next cycle count = 0, head = tail = 0, and any concurrent fetch word is discarded.
REQ-026 instr_data SHALL not change while instr_valid is high and no pop or flush occurs, regardless of pushes or waitrequest.
REQ-027 waitrequest high SHALL block pushes only; pops continue normally.
REQ-028 FIFO order SHALL be preserved: words leave in the order they were pushed.

Reset
REQ-029 While reset is high on a clock edge: count = 0, head = tail = 0, instr_valid = 0, instr_data = 0, fetch_ready = 1 next cycle.
REQ-030 Reset SHALL override flush, push and pop in the same cycle; storage contents need not be cleared but are never visible.
REQ-031 Reset asserted mid-operation (buffer partly full) SHALL discard all entries identically to REQ-029.

Verification
REQ-032 Reset, push 0x11111111, 0x22222222, 0x33333333 with consume=0 -> count=3, instr_data=0x11111111 held stable.
REQ-033 Fill DEPTH=4 with 0xA0..0xA3, push 0xA4 without consume -> fetch_ready=0, 0xA4 dropped; then consume 4 times -> outputs 0xA0,0xA1,0xA2,0xA3, count=0, instr_data=0.
REQ-034 Full buffer, push 0xB0 with consume in the same cycle -> count stays 4, head advances, 0xB0 appears last after 3 further pops (pointer wrap).
REQ-035 count=2, flush with fetch_valid=1 and consume=1 in the same cycle -> next cycle count=0, instr_valid=0, incoming word absent.
REQ-036 fetch_valid=1 with waitrequest=1 for 3 cycles, then waitrequest=0 with 0xC0 -> only 0xC0 pushed, count=1 next cycle.
REQ-037 count=3, reset pulsed with push and consume active -> count=0, instr_valid=0, instr_data=0, fetch_ready=1.

Source files
------------

// File: rtl/instr_fetch_buffer.sv
// -----------------------------------------------------------------------------
// instr_fetch_buffer
//
// Small circular FIFO that sits between the instruction memory read port and
// the decoder. Words returned by memory are queued at the tail; the decoder
// sees the head entry and pops it with `consume`. A `flush` (branch/jump
// redirect) empties the buffer and discards any word arriving that cycle.
//
// Parameters
//   DATA_WIDTH  instruction word width in bits
//   DEPTH       number of buffered words (power of two, >= 2)
//
// Ports
//   clk          clock, all state changes on the rising edge
//   reset        synchronous, active-high reset
//   waitrequest  memory stall; fetch_data is not valid while high
//   fetch_valid  memory returns a word this cycle (qualified by !waitrequest)
//   fetch_data   fetched instruction word
//   consume      decoder takes the head instruction this cycle
//   flush        discard every buffered instruction
//   fetch_ready  buffer can accept a word this cycle (combinational)
//   instr_valid  head entry holds a valid instruction
//   instr_data   head instruction, zero while empty
//   count        number of valid entries, 0..DEPTH
// -----------------------------------------------------------------------------
module instr_fetch_buffer #(
    parameter int DATA_WIDTH = 32,
    parameter int DEPTH      = 4
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         waitrequest,
    input  logic                         fetch_valid,
    input  logic [DATA_WIDTH-1:0]        fetch_data,
    input  logic                         consume,
    input  logic                         flush,
    output logic                         fetch_ready,
    output logic                         instr_valid,
    output logic [DATA_WIDTH-1:0]        instr_data,
    output logic [$clog2(DEPTH+1)-1:0]   count
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = $clog2(DEPTH + 1);
    localparam logic [CNT_W-1:0] FULL_COUNT = CNT_W'(DEPTH);

    // -------------------------------------------------------------------------
    // State
    // -------------------------------------------------------------------------
    logic [DATA_WIDTH-1:0] r_mem [DEPTH];
    logic [PTR_W-1:0]      r_head;
    logic [PTR_W-1:0]      r_tail;
    logic [CNT_W-1:0]      r_count;

    logic                  w_not_empty;
    logic                  w_has_room;
    logic                  w_push;
    logic                  w_pop;

    // -------------------------------------------------------------------------
    // Handshake decode
    // -------------------------------------------------------------------------
    always_comb begin
        w_not_empty = (r_count != '0);
        w_has_room  = (r_count < FULL_COUNT);

        // A full buffer still accepts a word when the head leaves this same
        // cycle: the freed slot is exactly the one the tail points at.
        fetch_ready = w_has_room || (consume && w_not_empty);

        // flush and reset win over everything, so they gate both strobes.
        w_push = fetch_valid && !waitrequest && fetch_ready && !flush && !reset;
        w_pop  = consume && w_not_empty && !flush && !reset;
    end

    // -------------------------------------------------------------------------
    // Storage
    // -------------------------------------------------------------------------
    // NOTE: the word array is deliberately not reset. Entries are only ever
    // shown through instr_data when count covers them, so stale contents are
    // invisible, and leaving the reset off lets the array map onto plain
    // register files or distributed RAM.
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_tail] <= fetch_data;
        end
    end

    // -------------------------------------------------------------------------
    // Pointers and occupancy
    // -------------------------------------------------------------------------
    // NOTE: sequential state is updated with non-blocking assignments only, so
    // every right-hand side below sees the pre-edge values of r_head, r_tail
    // and r_count regardless of statement order.
    always_ff @(posedge clk) begin
        if (reset || flush) begin
            r_head  <= '0;
            r_tail  <= '0;
            r_count <= '0;
        end else begin
            // DEPTH is a power of two, so natural pointer overflow is the
            // modulo-DEPTH wrap.
            if (w_push) begin
                r_tail <= r_tail + PTR_W'(1);
            end
            if (w_pop) begin
                r_head <= r_head + PTR_W'(1);
            end

            unique case ({w_push, w_pop})
                2'b10:   r_count <= r_count + CNT_W'(1);
                2'b01:   r_count <= r_count - CNT_W'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    // -------------------------------------------------------------------------
    // Outputs
    // -------------------------------------------------------------------------
    // instr_data is read from registered storage only, so a word written this
    // cycle becomes visible on the next one and there is no path from
    // fetch_data to instr_data. Pushes never move r_head, so the head word is
    // stable until a pop or flush.
    always_comb begin
        instr_valid = w_not_empty;
        instr_data  = w_not_empty ? r_mem[r_head] : '0;
        count       = r_count;
    end

endmodule

// File: tb/tb_instr_fetch_buffer.sv
// -----------------------------------------------------------------------------
// tb_instr_fetch_buffer
//
// Self-checking bench for instr_fetch_buffer (DATA_WIDTH=32, DEPTH=4).
// A queue-based reference model tracks the buffered words; directed sequences
// cover the named corner cases, then a long randomized run follows.
// -----------------------------------------------------------------------------
module tb_instr_fetch_buffer;

    localparam int DW    = 32;
    localparam int DEPTH = 4;
    localparam int CW    = $clog2(DEPTH + 1);

    logic          clk = 1'b0;
    logic          reset;
    logic          waitrequest;
    logic          fetch_valid;
    logic [DW-1:0] fetch_data;
    logic          consume;
    logic          flush;
    logic          fetch_ready;
    logic          instr_valid;
    logic [DW-1:0] instr_data;
    logic [CW-1:0] count;

    instr_fetch_buffer #(
        .DATA_WIDTH (DW),
        .DEPTH      (DEPTH)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .waitrequest (waitrequest),
        .fetch_valid (fetch_valid),
        .fetch_data  (fetch_data),
        .consume     (consume),
        .flush       (flush),
        .fetch_ready (fetch_ready),
        .instr_valid (instr_valid),
        .instr_data  (instr_data),
        .count       (count)
    );

    always #5 clk = ~clk;

    int unsigned n_checks = 0;
    int unsigned n_fail   = 0;

    // Reference model: the buffered words in arrival order.
    logic [DW-1:0] model_q[$];
    bit            model_known = 1'b0;

    task automatic check(input string tag, input logic [DW-1:0] actual,
                         input logic [DW-1:0] expected);
        n_checks++;
        if (actual !== expected) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", tag, actual, expected, $time);
        end
    endtask

    // One clock cycle: drive inputs after the falling edge, check the
    // combinational ready, let the rising edge happen, update the model and
    // check the registered outputs shortly afterwards.
    task automatic step(input logic rst, input logic fv, input logic wr,
                        input logic cons, input logic fl, input logic [DW-1:0] data);
        bit exp_ready;
        bit do_push;
        bit do_pop;
        @(negedge clk);
        reset       = rst;
        fetch_valid = fv;
        waitrequest = wr;
        consume     = cons;
        flush       = fl;
        fetch_data  = data;
        #1;
        exp_ready = (model_q.size() < DEPTH) || (cons && model_q.size() != 0);
        if (model_known) begin
            check("fetch_ready", {31'b0, fetch_ready}, {31'b0, exp_ready});
        end

        @(posedge clk);
        #1;
        if (rst) begin
            model_q.delete();
            model_known = 1'b1;
        end else if (fl) begin
            model_q.delete();
        end else begin
            do_pop  = cons && (model_q.size() != 0);
            do_push = fv && !wr && exp_ready;
            if (do_pop)  void'(model_q.pop_front());
            if (do_push) model_q.push_back(data);
        end

        if (model_known) begin
            check("count", DW'(count), DW'(model_q.size()));
            check("instr_valid", {31'b0, instr_valid}, {31'b0, (model_q.size() != 0)});
            check("instr_data", instr_data, (model_q.size() != 0) ? model_q[0] : '0);
        end
    endtask

    task automatic push(input logic [DW-1:0] data);
        step(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, data);
    endtask

    task automatic pop();
        step(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, '0);
    endtask

    task automatic idle();
        step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, '0);
    endtask

    initial begin
        reset       = 1'b1;
        waitrequest = 1'b0;
        fetch_valid = 1'b0;
        fetch_data  = '0;
        consume     = 1'b0;
        flush       = 1'b0;

        // Reset state
        step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, '0);
        step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, '0);
        check("rst_count", DW'(count), 32'd0);
        check("rst_ready", {31'b0, fetch_ready}, 32'd1);
        check("rst_data",  instr_data, 32'd0);

        // Three pushes, no consume: head holds the first word
        push(32'h1111_1111);
        check("lat1_data", instr_data, 32'h1111_1111);
        push(32'h2222_2222);
        push(32'h3333_3333);
        idle();
        check("three_count", DW'(count), 32'd3);
        check("three_head",  instr_data, 32'h1111_1111);

        // Fill, overflow attempt, drain
        step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, '0);
        for (int i = 0; i < DEPTH; i++) push(32'hA0 + 32'(i));
        push(32'hA4);
        check("full_ready_low", {31'b0, fetch_ready}, 32'd0);
        check("full_count", DW'(count), 32'd4);
        for (int i = 0; i < DEPTH; i++) begin
            check("drain_order", instr_data, 32'hA0 + 32'(i));
            pop();
        end
        check("drained_count", DW'(count), 32'd0);
        check("drained_data",  instr_data, 32'd0);

        // Full buffer with simultaneous push and pop, then pointer wrap
        for (int i = 0; i < DEPTH; i++) push(32'h90 + 32'(i));
        step(1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 32'hB0);
        check("pp_full_count", DW'(count), 32'd4);
        check("pp_full_head",  instr_data, 32'h91);
        pop(); pop(); pop();
        check("wrap_last", instr_data, 32'hB0);
        check("wrap_count", DW'(count), 32'd1);
        pop();

        // Flush beats a concurrent push and pop
        push(32'h55); push(32'h66);
        step(1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 32'h77);
        check("flush_count", DW'(count), 32'd0);
        check("flush_valid", {31'b0, instr_valid}, 32'd0);
        idle();
        check("flush_no_word", DW'(count), 32'd0);

        // Stalled fetches are ignored
        for (int i = 0; i < 3; i++) step(1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 32'hDEAD_0000 + 32'(i));
        check("stall_count", DW'(count), 32'd0);
        push(32'hC0);
        check("unstall_count", DW'(count), 32'd1);
        check("unstall_data",  instr_data, 32'hC0);
        pop();

        // Reset mid-operation overrides push and consume
        push(32'h1); push(32'h2); push(32'h3);
        step(1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 32'h4);
        check("midrst_count", DW'(count), 32'd0);
        check("midrst_valid", {31'b0, instr_valid}, 32'd0);
        check("midrst_data",  instr_data, 32'd0);
        check("midrst_ready", {31'b0, fetch_ready}, 32'd1);

        // Randomized traffic against the model
        for (int i = 0; i < 3000; i++) begin
            step(($urandom_range(0, 199) == 0),
                 ($urandom_range(0, 99) < 65),
                 ($urandom_range(0, 99) < 20),
                 ($urandom_range(0, 99) < 50),
                 ($urandom_range(0, 99) < 4),
                 $urandom());
        end

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
